// File: rtl/snn_pkt_pkg.sv
// Shared result-packet layout for the receive side: field offsets, packet width and collector states.
// Pure definitions; no timing or flow control.
package snn_pkt_pkg;

  localparam int DIR_LSB   = 0;
  localparam int XHOP_LSB  = 2;
  localparam int YHOP_BIT  = 4;
  localparam int TS_BIT    = 5;
  localparam int RSV_LSB   = 6;
  localparam int RSV_W     = 3;
  localparam int SPIKE_BIT = 9;
  localparam int NODE_LSB  = 10;
  localparam int NODE_W    = 2;
  localparam int PAD_LSB   = 12;
  // Residue offset moves with the residue width; RES_LSB is the value for the default W=8.
  localparam int RES_LSB   = 9 + 2*8;

  function automatic int res_lsb(input int w);
    return 9 + 2*w;
  endfunction

  function automatic int pkt_width(input int w);
    return 9 + 3*w;
  endfunction

  typedef enum logic {COLLECT, EMIT} collect_state_t;

endpackage

// File: rtl/pkt_unpack.sv
// Combinational result-packet field extraction; zero latency, no flow control.
// rsv_ok is high when the reserved bits and the zero pad are all clear.
module pkt_unpack
  import snn_pkt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [pkt_width(W)-1:0] pkt,
  output logic                    ts,
  output logic                    spike,
  output logic [NODE_W-1:0]       node,
  output logic [W-1:0]            residue,
  output logic                    rsv_ok
);

  localparam int RL    = res_lsb(W);
  localparam int PAD_W = RL - PAD_LSB;

  logic unused_route;

  assign ts      = pkt[TS_BIT];
  assign spike   = pkt[SPIKE_BIT];
  assign node    = pkt[NODE_LSB +: NODE_W];
  assign residue = pkt[RL +: W];
  assign rsv_ok  = (pkt[RSV_LSB +: RSV_W] == '0) && (pkt[PAD_LSB +: PAD_W] == '0);

  // Routing fields are consumed upstream; nothing here depends on them.
  assign unused_route = ^pkt[YHOP_BIT:DIR_LSB];

endmodule

// File: rtl/pe_result_collector.sv
// Collects one spike+residue per PE node into a result word; out_valid one cycle after the completing accept.
// Backpressure: pkt_ready drops for the whole EMIT state; optional PKT_CHECK_EN adds reserved/pad and timestep checks.
module pe_result_collector
  import snn_pkt_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int NUM_PE       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [pkt_width(FILTER_WIDTH)-1:0] pkt_data,
  input  logic                             pkt_valid,
  output logic                             pkt_ready,
  output logic                             out_timestep,
  output logic [NUM_PE-1:0]                out_spikes,
  output logic [NUM_PE*FILTER_WIDTH-1:0]   out_residues,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             err_dup,
  output logic                             err_ts
);

  localparam int W = FILTER_WIDTH;
  localparam logic [NUM_PE-1:0] ALL_GOT = '1;

  collect_state_t state, state_nxt;

  logic [NUM_PE-1:0] got_mask;
  logic              ts_lock;
  logic              ts_reg;

  logic              p_ts;
  logic              p_spike;
  logic [NODE_W-1:0] p_node;
  logic [W-1:0]      p_res;
  logic              p_rsv_ok;

  logic [NUM_PE-1:0] node_oh;
  logic              take;
  logic              store;
  logic              dup_hit;

  pkt_unpack #(.W(W)) u_unpack (
    .pkt     (pkt_data),
    .ts      (p_ts),
    .spike   (p_spike),
    .node    (p_node),
    .residue (p_res),
    .rsv_ok  (p_rsv_ok)
  );

  assign pkt_ready    = (state == COLLECT);
  assign out_valid    = (state == EMIT);
  assign out_timestep = ts_reg;

`ifdef PKT_CHECK_EN
  logic ts_hit;

  always_comb begin
    // Nodes beyond NUM_PE shift out of the one-hot and are silently dropped.
    node_oh = NUM_PE'(1) << p_node;
    take    = pkt_valid && pkt_ready && (node_oh != '0);
    store   = 1'b0;
    dup_hit = 1'b0;
    ts_hit  = 1'b0;
    if (take) begin
      if (!p_rsv_ok)                       ts_hit  = 1'b1;
      else if ((got_mask & node_oh) != '0) dup_hit = 1'b1;
      else if (ts_lock && (p_ts != ts_reg)) ts_hit = 1'b1;
      else                                 store   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_ts <= 1'b0;
    else if (ts_hit) err_ts <= 1'b1;
  end
`else
  logic unused_rsv_ok;

  always_comb begin
    node_oh = NUM_PE'(1) << p_node;
    take    = pkt_valid && pkt_ready && (node_oh != '0);
    store   = 1'b0;
    dup_hit = 1'b0;
    if (take) begin
      if ((got_mask & node_oh) != '0) dup_hit = 1'b1;
      else                            store   = 1'b1;
    end
  end

  assign unused_rsv_ok = p_rsv_ok;
  assign err_ts        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (store && ((got_mask | node_oh) == ALL_GOT)) state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got_mask     <= '0;
      ts_lock      <= 1'b0;
      ts_reg       <= 1'b0;
      out_spikes   <= '0;
      out_residues <= '0;
      err_dup      <= 1'b0;
    end else begin
      if (store) begin
        got_mask <= got_mask | node_oh;
        if (!ts_lock) begin
          ts_reg  <= p_ts;
          ts_lock <= 1'b1;
        end
        for (int n = 0; n < NUM_PE; n++) begin
          if (node_oh[n]) begin
            out_spikes[n]         <= p_spike;
            out_residues[n*W +: W] <= p_res;
          end
        end
      end
      if (dup_hit) err_dup <= 1'b1;
      // Stored spike/residue values are left in place; the next set overwrites every node.
      if ((state == EMIT) && out_ready) begin
        got_mask <= '0;
        ts_lock  <= 1'b0;
      end
    end
  end

endmodule
